// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BYTE_W     = 8;

  // Access width codes; 2'b11 is treated as a word.
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_TAIL = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // Request payload selected by the arbiter at grant time.
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        width;
    logic              we;
    logic              sgn;
    src_e              src;
  } req_t;

  // Index of the last byte of an access (byte count minus one).
  function automatic logic [1:0] last_idx(input logic [1:0] width);
    case (width)
      W_BYTE:  last_idx = 2'd0;
      W_HALF:  last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM port bundle of the memory controller.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = mem_ctrl_pkg::ADDR_W_DEF
);
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic              flush_i;
  logic              if_done_o;
  logic [31:0]       if_data_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [1:0]        mem_width_i;
  logic              mem_signed_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_done_o;
  logic [31:0]       mem_rdata_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;
  logic              busy_o;

  // Controller side.
  modport slave (
    input  if_req_i, if_addr_i, flush_i, mem_req_i, mem_we_i, mem_addr_i,
           mem_width_i, mem_signed_i, mem_wdata_i, ram_din_i,
    output if_done_o, if_data_o, mem_done_o, mem_rdata_o, ram_a_o, ram_wr_o,
           ram_dout_o, busy_o
  );

  // Pipeline/RAM environment side.
  modport master (
    output if_req_i, if_addr_i, flush_i, mem_req_i, mem_we_i, mem_addr_i,
           mem_width_i, mem_signed_i, mem_wdata_i, ram_din_i,
    input  if_done_o, if_data_o, mem_done_o, mem_rdata_o, ram_a_o, ram_wr_o,
           ram_dout_o, busy_o
  );
endinterface

// File: rtl/mem_byte_pack.sv
// Zero/sign extension of an assembled little-endian load by access width.
module mem_byte_pack
  import mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_width,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_word
);

  // Replicate the top valid bit (or zero) above the loaded bytes.
  always_comb begin
    o_word = i_word;
    case (i_width)
      W_BYTE:  o_word = {{24{i_signed & i_word[7]}}, i_word[7:0]};
      W_HALF:  o_word = {{16{i_signed & i_word[15]}}, i_word[15:0]};
      default: o_word = i_word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbiter + byte-serial controller sharing one 8-bit synchronous RAM port
// between instruction fetch and the load/store path.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  state_e              r_state;
  state_e              w_nxt_state;
  req_t                w_req;
  logic                w_grant;
  logic                w_flush_if;
  logic                w_if_done;
  logic                w_cap_en;
  src_e                r_src;
  logic                r_sgn;
  logic [1:0]          r_width;
  logic [1:0]          r_last;
  logic [1:0]          r_cnt;
  logic [1:0]          w_nxt_cnt;
  logic [1:0]          w_cap_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_asm;
  logic [DATA_W-1:0]   w_asm_cap;
  logic [DATA_W-1:0]   w_load_data;
  logic [DATA_W-1:0]   r_if_data;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic [ADDR_W-1:0]   r_ram_a;
  logic                r_ram_wr;
  logic [BYTE_W-1:0]   r_ram_dout;
  logic [BYTE_W-1:0]   w_wr_byte;
  logic                r_busy;
  logic                w_unused;

  // Upper address bits beyond the RAM width are intentionally ignored.
  assign w_unused = ^{bus.if_addr_i, bus.mem_addr_i, w_req};

  // Arbiter: MEM wins; a flush in IDLE blocks a coincident fetch grant.
  always_comb begin
    w_req = '{addr: bus.if_addr_i, wdata: '0, width: W_WORD, we: 1'b0,
              sgn: 1'b0, src: SRC_IF};
    if (bus.mem_req_i) begin
      w_req = '{addr: bus.mem_addr_i, wdata: bus.mem_wdata_i,
                width: bus.mem_width_i, we: bus.mem_we_i,
                sgn: bus.mem_signed_i, src: SRC_MEM};
    end
  end

  assign w_grant    = bus.mem_req_i | (bus.if_req_i & ~bus.flush_i);
  assign w_flush_if = bus.flush_i & (r_src == SRC_IF);
  assign w_nxt_cnt  = r_cnt + 2'd1;
  assign w_wr_byte  = r_wdata[{w_nxt_cnt, 3'b000} +: BYTE_W];
  assign w_cap_idx  = (r_state == ST_RD_TAIL) ? r_last : (r_cnt - 2'd1);
  assign w_cap_en   = ((r_state == ST_RD) && (r_cnt != 2'd0)) ||
                      (r_state == ST_RD_TAIL);

  // Merge the byte arriving on ram_din_i into the assembly register image.
  always_comb begin
    w_asm_cap = r_asm;
    w_asm_cap[{w_cap_idx, 3'b000} +: BYTE_W] = bus.ram_din_i;
  end

  mem_byte_pack u_pack (
    .i_word   (w_asm_cap),
    .i_width  (r_width),
    .i_signed (r_sgn),
    .o_word   (w_load_data)
  );

  // Next-state logic.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) w_nxt_state = w_req.we ? ST_WR : ST_RD;
      end
      ST_RD: begin
        if (w_flush_if)           w_nxt_state = ST_IDLE;
        else if (r_cnt == r_last) w_nxt_state = ST_RD_TAIL;
      end
      ST_RD_TAIL: begin
        w_nxt_state = w_flush_if ? ST_IDLE : ST_DONE;
      end
      ST_WR: begin
        if (r_cnt == r_last) w_nxt_state = ST_DONE;
      end
      ST_DONE: w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nxt_state;
  end

  // Request latch, byte sequencing, RAM port drive and load assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src       <= SRC_IF;
      r_sgn       <= 1'b0;
      r_width     <= 2'b00;
      r_last      <= 2'd0;
      r_cnt       <= 2'd0;
      r_wdata     <= '0;
      r_asm       <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_ram_a     <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_nxt_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_src      <= w_req.src;
            r_sgn      <= w_req.sgn;
            r_width    <= w_req.width;
            r_last     <= last_idx(w_req.width);
            r_cnt      <= 2'd0;
            r_wdata    <= w_req.wdata;
            r_asm      <= '0;
            r_ram_a    <= w_req.addr[ADDR_W-1:0];
            r_ram_wr   <= w_req.we;
            r_ram_dout <= w_req.we ? w_req.wdata[BYTE_W-1:0] : '0;
          end
        end
        ST_RD: begin
          if (w_cap_en) r_asm <= w_asm_cap;
          if (r_cnt != r_last) begin
            r_cnt   <= w_nxt_cnt;
            r_ram_a <= r_ram_a + ADDR_W'(1);
          end
        end
        ST_RD_TAIL: begin
          r_asm <= w_asm_cap;
          if (r_src == SRC_MEM) r_mem_rdata <= w_load_data;
        end
        ST_WR: begin
          if (r_cnt != r_last) begin
            r_cnt      <= w_nxt_cnt;
            r_ram_a    <= r_ram_a + ADDR_W'(1);
            r_ram_dout <= w_wr_byte;
          end else begin
            r_ram_wr   <= 1'b0;
            r_ram_dout <= '0;
          end
        end
        ST_DONE: begin
          if (w_if_done) r_if_data <= r_asm;
        end
        default: ;
      endcase
    end
  end

  // Fetch result is committed only when its done pulse survives a flush.
  assign w_if_done       = (r_state == ST_DONE) && (r_src == SRC_IF) && !bus.flush_i;
  assign bus.if_done_o   = w_if_done;
  assign bus.if_data_o   = w_if_done ? r_asm : r_if_data;
  assign bus.mem_done_o  = (r_state == ST_DONE) && (r_src == SRC_MEM);
  assign bus.mem_rdata_o = r_mem_rdata;
  assign bus.ram_a_o     = r_ram_a;
  assign bus.ram_wr_o    = r_ram_wr;
  assign bus.ram_dout_o  = r_ram_dout;
  assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural byte RAM.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned AW     = ADDR_W_DEF;
  localparam int unsigned RAM_SZ = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] ram [RAM_SZ];
  int checks = 0;
  int failures = 0;
  int n_if_done = 0;
  int n_mem_done = 0;

  mem_ctrl_if #(.ADDR_W(AW)) bus ();

  mem_ctrl #(.ADDR_W(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after its address.
  always @(posedge clk) begin
    bus.ram_din_i <= ram[bus.ram_a_o];
    if (bus.ram_wr_o) ram[bus.ram_a_o] = bus.ram_dout_o;
  end

  always @(posedge clk) begin
    if (bus.if_done_o)  n_if_done++;
    if (bus.mem_done_o) n_mem_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.flush_i      = 1'b0;
    bus.mem_req_i    = 1'b0;
    bus.mem_we_i     = 1'b0;
    bus.mem_addr_i   = '0;
    bus.mem_width_i  = 2'b00;
    bus.mem_signed_i = 1'b0;
    bus.mem_wdata_i  = '0;
  endtask

  task automatic mem_issue(input logic we, input logic [31:0] addr,
                           input logic [1:0] width, input logic sgn,
                           input logic [31:0] wdata);
    bus.mem_req_i    = 1'b1;
    bus.mem_we_i     = we;
    bus.mem_addr_i   = addr;
    bus.mem_width_i  = width;
    bus.mem_signed_i = sgn;
    bus.mem_wdata_i  = wdata;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.ram_wr_o, bus.busy_o, bus.if_done_o, bus.mem_done_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000",
               {bus.ram_wr_o, bus.busy_o, bus.if_done_o, bus.mem_done_o});
    end
    checks++;
    if ({bus.if_data_o, bus.mem_rdata_o} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {bus.if_data_o, bus.mem_rdata_o});
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o);
    end
  endtask

  task automatic test_reset_mid_write();
    int md;
    md = n_mem_done;
    mem_issue(1'b1, 32'h300, W_WORD, 1'b0, 32'h11223344);
    tick(); tick();
    checks++;
    if ({bus.ram_wr_o, bus.ram_dout_o} !== {1'b1, 8'h33}) begin
      failures++;
      $display("FAIL rmw_byte1 got=%b/%h exp=1/33", bus.ram_wr_o, bus.ram_dout_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.ram_wr_o, bus.busy_o} !== 2'b00) begin
      failures++;
      $display("FAIL rmw_async got=%b exp=00", {bus.ram_wr_o, bus.busy_o});
    end
    clear_inputs();
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (bus.busy_o !== 1'b0 || n_mem_done != md) begin
      failures++;
      $display("FAIL rmw_after busy=%b dones=%0d exp busy=0 dones=%0d",
               bus.busy_o, n_mem_done, md);
    end
  endtask

  task automatic test_if_word();
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h00;
    ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.ram_a_o !== AW'(32'h100 + k)) begin
        failures++;
        $display("FAIL if_addr_k%0d got=%h exp=%h", k, bus.ram_a_o, AW'(32'h100 + k));
      end
      tick();
    end
    checks++;
    if (bus.if_done_o !== 1'b0) begin
      failures++; $display("FAIL if_early_done got=%b exp=0", bus.if_done_o);
    end
    tick();
    checks++;
    if (bus.if_done_o !== 1'b1 || bus.if_data_o !== 32'h00000013) begin
      failures++;
      $display("FAIL if_word done=%b data=%h exp 1/00000013", bus.if_done_o, bus.if_data_o);
    end
    bus.if_req_i = 1'b0;
    tick();
    checks++;
    if (bus.if_done_o !== 1'b0 || bus.if_data_o !== 32'h00000013) begin
      failures++;
      $display("FAIL if_hold done=%b data=%h exp 0/00000013", bus.if_done_o, bus.if_data_o);
    end
  endtask

  task automatic test_byte_load();
    int lat;
    ram[32'h205] = 8'h80;
    for (int s = 1; s >= 0; s--) begin
      mem_issue(1'b0, 32'h205, W_BYTE, s[0], 32'h0);
      tick();
      lat = 1;
      while (!bus.mem_done_o && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat != 3 || bus.mem_rdata_o !== (s ? 32'hFFFFFF80 : 32'h00000080)) begin
        failures++;
        $display("FAIL byte_load_s%0d lat=%0d data=%h exp lat=3 data=%h", s, lat,
                 bus.mem_rdata_o, (s ? 32'hFFFFFF80 : 32'h00000080));
      end
      clear_inputs();
      tick();
    end
  endtask

  task automatic test_half_load();
    int lat;
    ram[32'h207] = 8'h34; ram[32'h208] = 8'hF2;
    mem_issue(1'b0, 32'h207, W_HALF, 1'b1, 32'h0);
    tick();
    lat = 1;
    while (!bus.mem_done_o && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 4 || bus.mem_rdata_o !== 32'hFFFFF234) begin
      failures++;
      $display("FAIL half_load lat=%0d data=%h exp lat=4 data=FFFFF234", lat, bus.mem_rdata_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_half_store_wrap();
    ram[32'h1FFFF] = 8'h00; ram[32'h0] = 8'h00; ram[32'h1] = 8'h55;
    mem_issue(1'b1, 32'h1FFFF, W_HALF, 1'b0, 32'hDEADBEEF);
    tick();
    checks++;
    if ({bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o} !== {1'b1, 17'h1FFFF, 8'hEF}) begin
      failures++;
      $display("FAIL wrap_b0 wr=%b a=%h d=%h exp 1/1ffff/ef", bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o);
    end
    tick();
    checks++;
    if ({bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o} !== {1'b1, 17'h00000, 8'hBE}) begin
      failures++;
      $display("FAIL wrap_b1 wr=%b a=%h d=%h exp 1/00000/be", bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o);
    end
    tick();
    checks++;
    if (bus.ram_wr_o !== 1'b0 || bus.mem_done_o !== 1'b1) begin
      failures++;
      $display("FAIL wrap_done wr=%b done=%b exp 0/1", bus.ram_wr_o, bus.mem_done_o);
    end
    clear_inputs();
    tick();
    checks++;
    if ({ram[32'h1FFFF], ram[32'h0], ram[32'h1]} !== 24'hEFBE55) begin
      failures++;
      $display("FAIL wrap_ram got=%h exp=efbe55", {ram[32'h1FFFF], ram[32'h0], ram[32'h1]});
    end
    checks++;
    if (bus.mem_rdata_o !== 32'hFFFFF234) begin
      failures++; $display("FAIL store_keeps_rdata got=%h exp=FFFFF234", bus.mem_rdata_o);
    end
  endtask

  task automatic test_contention();
    int lat;
    int ifd;
    ram[32'h400] = 8'h78; ram[32'h401] = 8'h56; ram[32'h402] = 8'h34; ram[32'h403] = 8'h12;
    ram[32'h500] = 8'hEF; ram[32'h501] = 8'hBE; ram[32'h502] = 8'hAD; ram[32'h503] = 8'hDE;
    ifd = n_if_done;
    mem_issue(1'b0, 32'h400, 2'b11, 1'b0, 32'h0);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h500;
    tick();
    checks++;
    if (bus.ram_a_o !== 17'h400) begin
      failures++; $display("FAIL cont_mem_first got=%h exp=00400", bus.ram_a_o);
    end
    lat = 1;
    while (!bus.mem_done_o && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 6 || bus.mem_rdata_o !== 32'h12345678 || n_if_done != ifd) begin
      failures++;
      $display("FAIL cont_mem lat=%0d data=%h ifdones=%0d exp 6/12345678/%0d",
               lat, bus.mem_rdata_o, n_if_done, ifd);
    end
    bus.mem_req_i = 1'b0;
    tick();
    checks++;
    if (bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL cont_idle busy=%b exp=0", bus.busy_o);
    end
    tick();
    checks++;
    if (bus.busy_o !== 1'b1 || bus.ram_a_o !== 17'h500) begin
      failures++;
      $display("FAIL cont_if_grant busy=%b a=%h exp 1/00500", bus.busy_o, bus.ram_a_o);
    end
    lat = 1;
    while (!bus.if_done_o && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 6 || bus.if_data_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL cont_if lat=%0d data=%h exp 6/DEADBEEF", lat, bus.if_data_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush_rd();
    int lat;
    int ifd;
    ram[32'h600] = 8'hAA; ram[32'h601] = 8'hBB; ram[32'h602] = 8'hCC; ram[32'h603] = 8'hDD;
    ifd = n_if_done;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h600;
    tick(); tick(); tick();
    checks++;
    if (bus.ram_a_o !== 17'h602) begin
      failures++; $display("FAIL flush_at_b2 a=%h exp=00602", bus.ram_a_o);
    end
    bus.flush_i  = 1'b1;
    bus.if_req_i = 1'b0;
    mem_issue(1'b0, 32'h205, W_BYTE, 1'b1, 32'h0);
    tick();
    bus.flush_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle busy=%b exp=0", bus.busy_o);
    end
    tick();
    checks++;
    if (bus.busy_o !== 1'b1 || bus.ram_a_o !== 17'h205) begin
      failures++;
      $display("FAIL flush_mem_grant busy=%b a=%h exp 1/00205", bus.busy_o, bus.ram_a_o);
    end
    lat = 1;
    while (!bus.mem_done_o && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 3 || bus.mem_rdata_o !== 32'hFFFFFF80 || n_if_done != ifd ||
        bus.if_data_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL flush_rd lat=%0d rdata=%h ifdones=%0d ifdata=%h exp 3/FFFFFF80/%0d/DEADBEEF",
               lat, bus.mem_rdata_o, n_if_done, ifd, bus.if_data_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush_done();
    int ifd;
    ram[32'h700] = 8'h11; ram[32'h701] = 8'h22; ram[32'h702] = 8'h33; ram[32'h703] = 8'h44;
    ifd = n_if_done;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h700;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.if_done_o !== 1'b1 || bus.if_data_o !== 32'h44332211) begin
      failures++;
      $display("FAIL fdone_pre done=%b data=%h exp 1/44332211", bus.if_done_o, bus.if_data_o);
    end
    bus.flush_i = 1'b1;
    #1;
    checks++;
    if (bus.if_done_o !== 1'b0 || bus.if_data_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL fdone_suppress done=%b data=%h exp 0/DEADBEEF", bus.if_done_o, bus.if_data_o);
    end
    bus.if_req_i = 1'b0;
    tick();
    bus.flush_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.if_data_o !== 32'hDEADBEEF || n_if_done != ifd) begin
      failures++;
      $display("FAIL fdone_after busy=%b data=%h dones=%0d exp 0/DEADBEEF/%0d",
               bus.busy_o, bus.if_data_o, n_if_done, ifd);
    end
  endtask

  task automatic test_flush_idle_block();
    int lat;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;
    bus.flush_i   = 1'b1;
    tick();
    checks++;
    if (bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL fidle_block busy=%b exp=0", bus.busy_o);
    end
    bus.flush_i = 1'b0;
    tick();
    lat = 1;
    while (!bus.if_done_o && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 6 || bus.if_data_o !== 32'h00000013) begin
      failures++;
      $display("FAIL fidle_regrant lat=%0d data=%h exp 6/00000013", lat, bus.if_data_o);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < int'(RAM_SZ); i++) ram[i] = 8'h00;
    test_reset();
    test_reset_mid_write();
    test_if_word();
    test_byte_load();
    test_half_load();
    test_half_store_wrap();
    test_contention();
    test_flush_rd();
    test_flush_done();
    test_flush_idle_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory controller and arbiter sharing one byte-wide synchronous RAM port between instruction fetch (IF) and the load/store path fed by EX (MEM).
- Serialises 32/16/8-bit accesses into little-endian byte cycles.
- Assembles and sign-extends load data.
- Returns single-cycle done pulses.
- Exposes busy for pipeline stall logic.

Parameters:
ADDR_W, 17, RAM byte-address width; ram_a_o wraps modulo 2^ADDR_W.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
if_req_i  in  1  fetch request; held until if_done_o
if_addr_i  in  32  fetch byte address; always a word access
flush_i  in  1  cancel an in-flight IF access (jump/branch taken)
if_done_o  out  1  one-cycle pulse: if_data_o valid
if_data_o  out  32  fetched instruction
mem_req_i  in  1  load/store request; held until mem_done_o
mem_we_i  in  1  1 = store, 0 = load
mem_addr_i  in  32  effective address from EX
mem_width_i  in  2  00 = byte, 01 = half, 10/11 = word
mem_signed_i  in  1  sign-extend a load narrower than a word
mem_wdata_i  in  32  store data; low bytes are used
mem_done_o  out  1  one-cycle pulse: load data valid / store complete
mem_rdata_o  out  32  load result, extended
ram_a_o  out  ADDR_W  RAM byte address
ram_wr_o  out  1  RAM write strobe
ram_dout_o  out  8  RAM write byte
ram_din_i  in  8  RAM read byte; valid one cycle after its address
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0, including ram_wr_o, which drops immediately. Byte counter and data registers cleared. An in-flight access is discarded with no done.
- States: IDLE, RD, RD_TAIL, WR, DONE. Register cur_src = IF/MEM.
- IDLE: samples requests at a clock edge.
  - mem_req_i has priority over if_req_i.
  - Latches addr, n (1, 2 or 4 bytes; IF always 4), we, signed, wdata.
  - Next state is RD or WR.
- No preemption once granted.
- Grant at edge T; byte k (0..n-1) is issued in cycle T+1+k with ram_a_o = (addr + k) mod 2^ADDR_W.
- Read:
  - RD issues bytes 0..n-1.
  - Byte k is captured from ram_din_i at the edge ending cycle T+2+k.
  - After the last issue, RD_TAIL captures the final byte, then DONE.
  - done pulses in cycle T+n+2.
  - Latency from grant: word 6, half 4, byte 3 cycles.
- Write:
  - WR drives ram_wr_o = 1 and ram_dout_o = wdata byte k for k = 0..n-1.
  - Then DONE; done pulses in cycle T+n+1.
  - ram_wr_o is 0 in every other state.
- DONE:
  - Asserts if_done_o or mem_done_o per cur_src for exactly one cycle.
  - Data outputs hold their value until the next access completes.
  - Next state is always IDLE.
  - The requester drops its req by the next edge.
  - No regrant happens in the DONE cycle.
- Load extension:
  - byte: bits 31:8 = signed ? bit7 : 0.
  - half: bits 31:16 = signed ? bit15 : 0.
  - word: as assembled.
- Misaligned addresses are legal and handled byte-serially. Address wrap at 2^ADDR_W is silent.
- flush_i while cur_src = IF and state is RD/RD_TAIL/DONE:
  - Next state is IDLE.
  - if_done_o is suppressed, including in the same-cycle DONE case.
  - if_data_o is unchanged.
- flush_i has no effect on MEM accesses or in IDLE. A flush_i in IDLE coincident with if_req_i blocks that grant.
- Simultaneous if_req_i and mem_req_i in IDLE: MEM is served first; IF is granted at the first IDLE after MEM's DONE.

Decomposition:
- Shared package/defines file holds:
  - width codes (BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10)
  - state encodings
  - source IDs
  - the default RAM address width
- One combinational sub-module, mem_byte_pack, extends the assembled word by width/signed for load data.
- Serial write bytes are a plain mux in mem_ctrl.

Test Plan:
1. Reset mid-write: assert rst low during WR byte 1 -> ram_wr_o = 0 at once. After release: IDLE, no mem_done_o, busy_o = 0.
2. IF word read: RAM[0x100..0x103] = 13,00,00,00; if_req_i with addr 0x100 -> ram_a_o 0x100..0x103 on consecutive cycles; if_done_o 6 cycles after grant; if_data_o = 0x00000013.
3. Signed byte load: RAM[0x205] = 0x80; width 00, signed 1 -> mem_rdata_o = 0xFFFFFF80 with 3-cycle latency. Same with signed 0 -> 0x00000080.
4. Half store across wrap: addr 0x1FFFF, wdata 0xDEADBEEF, width 01 -> writes EF to 0x1FFFF and BE to 0x00000. mem_done_o at T+3. RAM[0x00001] untouched.
5. Contention: if_req_i and mem_req_i rise the same cycle (load word) -> MEM served first. IF granted the cycle after mem_done_o's DONE→IDLE transition. Both return correct data.
6. Flush: flush_i pulsed during IF RD byte 2 -> no if_done_o, back to IDLE next cycle, a pending mem_req_i is granted from that IDLE.
